// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: 32-cycle shift-add multiply and restoring divide,
// with sign fix-up in a final cycle and results held in HI/LO until the next completion.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0] OP_MULT  = 4'hA;
  localparam logic [3:0] OP_DIV   = 4'hB;
  localparam logic [3:0] OP_MULTU = 4'hC;
  localparam logic [3:0] OP_DIVU  = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_orig0;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH:0]       r_rem;

  logic                 r_busy;
  logic                 r_finish;
  logic                 r_div_zero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_op_ok;
  logic                 w_signed;
  logic                 w_div_op;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_done;
  logic [WIDTH-1:0]     w_mag0;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH:0]       w_msum;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH+1:0]     w_trial;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_hi_res;
  logic [WIDTH-1:0]     w_lo_res;

  assign w_op_ok  = (opcode == OP_MULT) || (opcode == OP_DIV) ||
                    (opcode == OP_MULTU) || (opcode == OP_DIVU);
  assign w_signed = (opcode == OP_MULT) || (opcode == OP_DIV);
  assign w_div_op = (opcode == OP_DIV) || (opcode == OP_DIVU);
  assign w_accept = (r_state == S_IDLE) && start && w_op_ok;
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_done   = (r_state == S_FIX) && !cancel;

  assign w_mag0 = (w_signed && data0[WIDTH-1]) ? f_neg(data0) : data0;
  assign w_mag1 = (w_signed && data1[WIDTH-1]) ? f_neg(data1) : data1;

  // Multiply step: add multiplicand into the upper half when the current multiplier bit is set.
  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                   (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  // Divide step: a borrow out of the trial subtraction means the quotient bit is 0.
  assign w_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_opnd};
  assign w_qbit  = ~w_trial[WIDTH+1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (cancel) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_FIX;
        end else begin
          w_next = S_CALC;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture at accept and one iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= CNT_ZERO;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_opnd   <= {WIDTH{1'b0}};
      r_orig0  <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_rem    <= {(WIDTH+1){1'b0}};
    end else if (w_accept) begin
      r_cnt    <= CNT_ZERO;
      r_is_div <= w_div_op;
      r_neg_q  <= w_signed & (data0[WIDTH-1] ^ data1[WIDTH-1]);
      r_neg_r  <= w_signed & data0[WIDTH-1];
      r_dz     <= w_div_op && (data1 == {WIDTH{1'b0}});
      r_orig0  <= data0;
      r_rem    <= {(WIDTH+1){1'b0}};
      // Divide keeps the divisor in r_opnd; multiply keeps the multiplicand there.
      if (w_div_op) begin
        r_opnd <= w_mag1;
        r_acc  <= {{WIDTH{1'b0}}, w_mag0};
      end else begin
        r_opnd <= w_mag0;
        r_acc  <= {{WIDTH{1'b0}}, w_mag1};
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= (cancel || w_last) ? CNT_ZERO : (r_cnt + CNT_ONE);
      if (r_is_div) begin
        r_rem <= w_qbit ? w_trial[WIDTH:0] : w_shift;
        r_acc <= {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], w_qbit};
      end else begin
        r_acc <= {w_msum, r_acc[WIDTH-1:1]};
      end
    end
  end

  // Final result selection with sign correction; divide-by-zero bypasses the fix-up.
  always_comb begin
    w_prod   = r_neg_q ? f_neg2(r_acc) : r_acc;
    w_hi_res = w_prod[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod[WIDTH-1:0];
    if (r_dz) begin
      w_hi_res = r_orig0;
      w_lo_res = {WIDTH{1'b1}};
    end else if (r_is_div) begin
      w_hi_res = r_neg_r ? f_neg(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
      w_lo_res = r_neg_q ? f_neg(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    end else begin
      w_hi_res = w_prod[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod[WIDTH-1:0];
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_finish   <= 1'b0;
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_div_zero <= 1'b0;
    end else begin
      r_busy   <= (w_next == S_CALC) || (w_next == S_FIX);
      r_finish <= w_done;
      if (w_done) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
      if (w_accept) begin
        r_div_zero <= 1'b0;
      end else if (w_done) begin
        r_div_zero <= r_dz;
      end
    end
  end

  assign busy     = r_busy;
  assign finish   = r_finish;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule
